axi_id_remapper: RTL

- Successor to the single-ID AXI4 ID killer. Compresses a wide slave-side ID space (ID_WIDTH) onto a narrow master-side ID space (M_ID_WIDTH), so transactions with different IDs can proceed concurrently downstream.
- Each master ID is a slot holding one slave ID and an outstanding-burst counter. Read and write have independent slot tables.
- Sits between an upstream multi-ID master and a downstream slave that supports only 2^M_ID_WIDTH IDs. The legacy killer is the case M_ID_WIDTH=0 (one slot).

---
 rtl/axi_id_remapper_if.sv | 78 +++++++
 rtl/axi_id_remapper.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axi_id_remapper_if.sv
// AXI4 bus bundle used on both sides of the ID remapper.
// The same interface is instantiated with a wide ID on the upstream side
// and a narrow ID on the downstream side.
interface axi_id_remapper_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;

    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_id_remapper.sv
// AXI4 ID remapper: folds a wide upstream ID space onto 2^M_ID_WIDTH
// downstream IDs. Each downstream ID is a slot remembering one upstream ID
// and how many bursts are outstanding on it; read and write keep separate
// slot tables. Request paths are combinational with no added latency.
module axi_id_remapper #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int M_ID_WIDTH     = 1,
    parameter int MAX_R_INFLIGHT = 8,
    parameter int MAX_W_INFLIGHT = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi_id_remapper_if.slave    s_axi,
    axi_id_remapper_if.master   m_axi,
    output logic                rd_idle,
    output logic                wr_idle
);
    localparam int NSLOT      = 1 << M_ID_WIDTH;
    localparam int MIDW       = (M_ID_WIDTH > 0) ? M_ID_WIDTH : 1;
    localparam int RCW        = $clog2(MAX_R_INFLIGHT + 1);
    localparam int WCW        = $clog2(MAX_W_INFLIGHT + 1);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [RCW-1:0] R_MAX = RCW'(MAX_R_INFLIGHT);
    localparam logic [WCW-1:0] W_MAX = WCW'(MAX_W_INFLIGHT);

    logic [ID_WIDTH-1:0] r_sid [NSLOT];
    logic [RCW-1:0]      r_cnt [NSLOT];
    logic [ID_WIDTH-1:0] w_sid [NSLOT];
    logic [WCW-1:0]      w_cnt [NSLOT];

    logic [MIDW-1:0]     r_sel, w_sel;
    logic                r_ok, w_ok;
    logic [NSLOT-1:0]    r_inc, r_dec, w_inc, w_dec;
    logic                ar_hs, aw_hs, r_done, b_done;
    logic [ID_WIDTH-1:0] s_rid, s_bid;

    assign ar_hs  = s_axi.arvalid & r_ok & m_axi.arready & aresetn;
    assign aw_hs  = s_axi.awvalid & w_ok & m_axi.awready & aresetn;
    assign r_done = m_axi.rvalid & s_axi.rready & m_axi.rlast & aresetn;
    assign b_done = m_axi.bvalid & s_axi.bready & aresetn;

    // Read slot choice: an existing slot for this ID wins (even when full, so
    // per-ID ordering is never split across slots), else the lowest free slot.
    always_comb begin
        r_sel = '0;
        r_ok  = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (r_cnt[i] == '0) begin
                r_sel = MIDW'(i);
                r_ok  = 1'b1;
            end
        end
        for (int i = 0; i < NSLOT; i++) begin
            if (r_cnt[i] != '0 && r_sid[i] == s_axi.arid) begin
                r_sel = MIDW'(i);
                r_ok  = (r_cnt[i] != R_MAX);
            end
        end
        for (int i = 0; i < NSLOT; i++) begin
            r_inc[i] = ar_hs && (r_sel == MIDW'(i));
            r_dec[i] = r_done && (m_axi.rid == MIDW'(i)) && (r_cnt[i] != '0);
        end
    end

    // Write slot choice, same policy as reads with its own depth limit.
    always_comb begin
        w_sel = '0;
        w_ok  = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (w_cnt[i] == '0) begin
                w_sel = MIDW'(i);
                w_ok  = 1'b1;
            end
        end
        for (int i = 0; i < NSLOT; i++) begin
            if (w_cnt[i] != '0 && w_sid[i] == s_axi.awid) begin
                w_sel = MIDW'(i);
                w_ok  = (w_cnt[i] != W_MAX);
            end
        end
        for (int i = 0; i < NSLOT; i++) begin
            w_inc[i] = aw_hs && (w_sel == MIDW'(i));
            w_dec[i] = b_done && (m_axi.bid == MIDW'(i)) && (w_cnt[i] != '0);
        end
    end

    // Read slot table: count bursts in on AR, out on the last R beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_cnt[i] <= '0;
                r_sid[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (r_inc[i] && !r_dec[i])
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (r_dec[i] && !r_inc[i])
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                if (r_inc[i] && r_cnt[i] == '0)
                    r_sid[i] <= s_axi.arid;
            end
        end
    end

    // Write slot table: count bursts in on AW, out on every B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NSLOT; i++) begin
                w_cnt[i] <= '0;
                w_sid[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (w_inc[i] && !w_dec[i])
                    w_cnt[i] <= w_cnt[i] + 1'b1;
                else if (w_dec[i] && !w_inc[i])
                    w_cnt[i] <= w_cnt[i] - 1'b1;
                if (w_inc[i] && w_cnt[i] == '0)
                    w_sid[i] <= s_axi.awid;
            end
        end
    end

    // Restore upstream IDs on responses and report idle when all slots are empty.
    always_comb begin
        s_rid   = r_sid[0];
        s_bid   = w_sid[0];
        rd_idle = 1'b1;
        wr_idle = 1'b1;
        for (int i = 0; i < NSLOT; i++) begin
            if (m_axi.rid == MIDW'(i)) s_rid = r_sid[i];
            if (m_axi.bid == MIDW'(i)) s_bid = w_sid[i];
            if (r_cnt[i] != '0) rd_idle = 1'b0;
            if (w_cnt[i] != '0) wr_idle = 1'b0;
        end
    end

    assign m_axi.awvalid  = s_axi.awvalid & w_ok & aresetn;
    assign s_axi.awready  = m_axi.awready & w_ok & aresetn;
    assign m_axi.awid     = w_sel;
    assign m_axi.awaddr   = ADDR_WIDTH'(s_axi.awaddr);
    assign m_axi.awlen    = s_axi.awlen;
    assign m_axi.awsize   = s_axi.awsize;
    assign m_axi.awburst  = s_axi.awburst;
    assign m_axi.awlock   = s_axi.awlock;
    assign m_axi.awcache  = s_axi.awcache;
    assign m_axi.awprot   = s_axi.awprot;
    assign m_axi.awqos    = s_axi.awqos;
    assign m_axi.awregion = s_axi.awregion;

    assign m_axi.wvalid   = s_axi.wvalid & aresetn;
    assign s_axi.wready   = m_axi.wready & aresetn;
    assign m_axi.wdata    = DATA_WIDTH'(s_axi.wdata);
    assign m_axi.wstrb    = STRB_WIDTH'(s_axi.wstrb);
    assign m_axi.wlast    = s_axi.wlast;

    assign s_axi.bvalid   = m_axi.bvalid & aresetn;
    assign m_axi.bready   = s_axi.bready & aresetn;
    assign s_axi.bid      = s_bid;
    assign s_axi.bresp    = m_axi.bresp;

    assign m_axi.arvalid  = s_axi.arvalid & r_ok & aresetn;
    assign s_axi.arready  = m_axi.arready & r_ok & aresetn;
    assign m_axi.arid     = r_sel;
    assign m_axi.araddr   = ADDR_WIDTH'(s_axi.araddr);
    assign m_axi.arlen    = s_axi.arlen;
    assign m_axi.arsize   = s_axi.arsize;
    assign m_axi.arburst  = s_axi.arburst;
    assign m_axi.arlock   = s_axi.arlock;
    assign m_axi.arcache  = s_axi.arcache;
    assign m_axi.arprot   = s_axi.arprot;
    assign m_axi.arqos    = s_axi.arqos;
    assign m_axi.arregion = s_axi.arregion;

    assign s_axi.rvalid   = m_axi.rvalid & aresetn;
    assign m_axi.rready   = s_axi.rready & aresetn;
    assign s_axi.rid      = s_rid;
    assign s_axi.rdata    = m_axi.rdata;
    assign s_axi.rresp    = m_axi.rresp;
    assign s_axi.rlast    = m_axi.rlast;
endmodule
